karatsuba_mul_pipe: RTL and testbench
=====================================

Name: karatsuba_mul_pipe

Overview:
- Parametrised, fully pipelined one-level Karatsuba multiplier: W x W -> 2W product.
- Three (W/2+1)-bit sub-multiplies instead of four.
- Successor to the fixed 128/192-bit fold multipliers. Adds:
  - generic operand width
  - per-transaction signed/unsigned mode
  - valid/ready backpressure on both sides
- Feeds the modular-reduction stage of the modular multiplier datapath.

Parameters:
- W, 128: operand width; must be even and >= 8.
- H, W/2: half width (derived localparam, not overridable).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand transaction valid
- in_ready  output  1  block can accept a transaction this cycle
- in_signed  input  1  1 = A and B are two's complement, 0 = unsigned
- A  input  W  multiplicand
- B  input  W  multiplier
- out_valid  output  1  P is valid
- out_ready  input  1  downstream accepts P this cycle
- P  output  2W  product; two's complement when the transaction was signed

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous, active-high.
  - Reset clears all stage valid bits, out_valid=0, P=0.
  - in_ready is 1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight transactions; no partial output is produced.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance=0, every stage register, including P and out_valid, holds.
  - P is stable while out_valid && !out_ready.
  - Bubbles propagate as invalid stages; no bubble collapsing is required.
- Pipeline, one stage per advance:
  - S1: if in_signed, take magnitudes |A|, |B| (W-bit unsigned; the magnitude of the most negative value is 2^(W-1), which fits). Record neg = in_signed & (A[W-1]^B[W-1]). Split into a1/a0 and b1/b0 (H bits each). Form sa = a1+a0 and sb = b1+b0 (H+1 bits each).
  - S2: p00 = a0*b0 (2H bits), p11 = a1*b1 (2H bits), pss = sa*sb (2H+2 bits).
  - S3: mid = pss - p11 - p00 (2H+1 bits; always non-negative).
  - S4: mag = {p11, p00} + (mid << H); 2W bits, no overflow possible.
  - S5: P = neg ? -mag : mag (2W-bit two's complement). out_valid is set.
- Timing and throughput:
  - Latency with no stalls is 5 cycles from input handshake to out_valid.
  - Throughput is one transaction per cycle.
  - Order is preserved.
- Boundary and mode rules:
  - Zero operands and neg=1 give P=0; no negative-zero issue.
  - Unsigned mode ignores the sign bits entirely.
  - in_signed travels with its transaction, so the mode can change every cycle.
- Simultaneous in and out handshakes in the same cycle are legal and required at full rate.

Optional Feature:
- KMUL_TAG_EN:
  - When defined, adds parameter TW (default 8) and ports in_tag (input, TW) and out_tag (output, TW).
  - The tag is captured with the operands, carried through all 5 stages, and presented with P.
  - out_tag resets to 0 and holds under stall exactly like P.
- When undefined, the tag ports and tag registers do not exist; all other behaviour is identical.

Test Plan:
- Unsigned, W=128: A=2^128-1, B=2^128-1, out_ready=1 -> out_valid exactly 5 cycles later, P=2^256-2^129+1.
- Signed, W=128: A=-1, B=3 -> P=-3 (all-ones except the low bits ...FFFD); A=-2^127, B=-2^127 -> P=2^254.
- Back-to-back: 20 random signed/unsigned pairs on consecutive cycles, out_ready=1 -> 20 consecutive correct products, in the same order, matching a behavioural reference.
- Backpressure: stream of 8 transactions, hold out_ready=0 for 6 cycles mid-stream -> P and out_valid frozen, in_ready=0 throughout, no loss or duplication, correct order after release.
- Reset mid-flight: 3 transactions in flight, assert reset 1 cycle -> out_valid=0 and P=0 next cycle, no stale output afterward, a new transaction 5 7x9 completes with P=63.
- W=16 instance: exhaustive sweep of 0, 1, 0x7FFF, 0x8000, 0xFFFF in both modes -> all products match a reference model (with KMUL_TAG_EN, out_tag equals the launched tag).

Source files
------------

// File: rtl/karatsuba_mul_pipe.sv
// Five-stage, fully pipelined one-level Karatsuba multiplier (W x W -> 2W), signed/unsigned per transaction.
// Optional KMUL_TAG_EN adds a TW-bit tag that travels alongside each transaction.
module karatsuba_mul_pipe #(
    parameter int unsigned W = 128
`ifdef KMUL_TAG_EN
    ,
    parameter int unsigned TW = 8
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
`ifdef KMUL_TAG_EN
    input  logic [TW-1:0]    in_tag,
    output logic [TW-1:0]    out_tag,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   P
);

    localparam int unsigned H   = W / 2;
    localparam int unsigned SW  = H + 1;
    localparam int unsigned PW  = 2 * H;
    localparam int unsigned SSW = 2 * H + 2;
    localparam int unsigned MW  = 2 * H + 1;
    localparam int unsigned DW  = 2 * W;

    logic           advance;
    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;

    logic           v1, v2, v3, v4;
    logic           neg1, neg2, neg3, neg4;
    logic [H-1:0]   a0_1, a1_1, b0_1, b1_1;
    logic [SW-1:0]  sa_1, sb_1;
    logic [PW-1:0]  p00_2, p11_2;
    logic [SSW-1:0] pss_2;
    logic [PW-1:0]  p00_3, p11_3;
    logic [MW-1:0]  mid_3;
    logic [DW-1:0]  mag_4;
`ifdef KMUL_TAG_EN
    logic [TW-1:0]  t1, t2, t3, t4;
`endif

    // Whole pipeline moves as one unit; it only stops when a result is waiting to be taken.
    always_comb begin
        advance  = !out_valid || out_ready;
        in_ready = advance;
        abs_a    = (in_signed && A[W-1]) ? W'(-A) : A;
        abs_b    = (in_signed && B[W-1]) ? W'(-B) : B;
    end

    // Stage valids and the output register; these are the only state that needs reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            v4        <= 1'b0;
            out_valid <= 1'b0;
            P         <= '0;
`ifdef KMUL_TAG_EN
            out_tag   <= '0;
`endif
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            v4        <= v3;
            out_valid <= v4;
            if (v4) begin
                P       <= neg4 ? DW'(-mag_4) : mag_4;
`ifdef KMUL_TAG_EN
                out_tag <= t4;
`endif
            end
        end
    end

    // Datapath registers load only when the stage feeding them holds a live transaction.
    always_ff @(posedge clock) begin
        if (advance) begin
            if (in_valid) begin
                neg1 <= in_signed & (A[W-1] ^ B[W-1]);
                a0_1 <= abs_a[H-1:0];
                a1_1 <= abs_a[W-1:H];
                b0_1 <= abs_b[H-1:0];
                b1_1 <= abs_b[W-1:H];
                sa_1 <= SW'(abs_a[W-1:H]) + SW'(abs_a[H-1:0]);
                sb_1 <= SW'(abs_b[W-1:H]) + SW'(abs_b[H-1:0]);
`ifdef KMUL_TAG_EN
                t1   <= in_tag;
`endif
            end
            if (v1) begin
                neg2  <= neg1;
                p00_2 <= PW'(a0_1) * PW'(b0_1);
                p11_2 <= PW'(a1_1) * PW'(b1_1);
                pss_2 <= SSW'(sa_1) * SSW'(sb_1);
`ifdef KMUL_TAG_EN
                t2    <= t1;
`endif
            end
            if (v2) begin
                neg3  <= neg2;
                p00_3 <= p00_2;
                p11_3 <= p11_2;
                mid_3 <= MW'(pss_2 - SSW'(p11_2) - SSW'(p00_2));
`ifdef KMUL_TAG_EN
                t3    <= t2;
`endif
            end
            if (v3) begin
                neg4  <= neg3;
                mag_4 <= {p11_3, p00_3} + (DW'(mid_3) << H);
`ifdef KMUL_TAG_EN
                t4    <= t3;
`endif
            end
        end
    end

endmodule

// File: tb/tb_karatsuba_mul_pipe.sv
// Scoreboard bench for karatsuba_mul_pipe: a W=128 and a W=16 instance checked against wide-multiply references.
module tb_karatsuba_mul_pipe;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic         iv, ir, isg, ov, ordy;
    logic [127:0] a, b;
    logic [255:0] p;
    logic         iv16, ir16, isg16, ov16, or16;
    logic [15:0]  a16, b16;
    logic [31:0]  p16;
`ifdef KMUL_TAG_EN
    logic [7:0]   it, ot, it16, ot16;
    logic [7:0]   tq16[$];
`endif

    int total = 0;
    int bad = 0;
    logic [255:0] sb128[$];
    logic [31:0]  sb16[$];

    karatsuba_mul_pipe #(.W(128)) dut (
        .clock(clock), .reset(reset), .in_valid(iv), .in_ready(ir), .in_signed(isg),
        .A(a), .B(b),
`ifdef KMUL_TAG_EN
        .in_tag(it), .out_tag(ot),
`endif
        .out_valid(ov), .out_ready(ordy), .P(p));

    karatsuba_mul_pipe #(.W(16)) dut16 (
        .clock(clock), .reset(reset), .in_valid(iv16), .in_ready(ir16), .in_signed(isg16),
        .A(a16), .B(b16),
`ifdef KMUL_TAG_EN
        .in_tag(it16), .out_tag(ot16),
`endif
        .out_valid(ov16), .out_ready(or16), .P(p16));

    function automatic logic [255:0] ref128(input logic [127:0] x, input logic [127:0] y, input logic s);
        logic [255:0] ex, ey;
        ex = s ? {{128{x[127]}}, x} : {128'b0, x};
        ey = s ? {{128{y[127]}}, y} : {128'b0, y};
        return ex * ey;
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [31:0] ex, ey;
        ex = s ? {{16{x[15]}}, x} : {16'b0, x};
        ey = s ? {{16{y[15]}}, y} : {16'b0, y};
        return ex * ey;
    endfunction

    task automatic test_reset;
        reset = 1'b1; iv = 1'b0; isg = 1'b0; a = '0; b = '0; ordy = 1'b1;
        iv16 = 1'b0; isg16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
`ifdef KMUL_TAG_EN
        it = '0; it16 = '0;
`endif
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", ov); end
        total++; if (p !== '0) begin bad++; $display("FAIL reset_p got=%h want=0", p); end
        total++; if (ir !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", ir); end
        total++; if (ov16 !== 1'b0 || p16 !== '0) begin bad++; $display("FAIL reset_w16 got=%b/%h want=0/0", ov16, p16); end
`ifdef KMUL_TAG_EN
        total++; if (ot16 !== '0) begin bad++; $display("FAIL reset_tag got=%h want=0", ot16); end
`endif
    endtask

    task automatic test_unsigned_max;
        logic [255:0] e;
        int lat;
        bit seen;
        e = {{127{1'b1}}, 128'b0, 1'b1};
        @(posedge clock); #1;
        iv = 1'b1; isg = 1'b0; a = '1; b = '1; ordy = 1'b1;
        lat = 0; seen = 0;
        while (!seen && lat < 20) begin
            @(posedge clock);
            lat++;
            if (lat == 1) #1 iv = 1'b0;
            @(negedge clock);
            if (ov) seen = 1;
        end
        total++; if (!seen || lat != 5) begin bad++; $display("FAIL umax_latency got=%0d want=5", lat); end
        total++; if (p !== e) begin bad++; $display("FAIL umax_p got=%h want=%h", p, e); end
        @(posedge clock); @(negedge clock);
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL umax_single got=%b want=0", ov); end
    endtask

    task automatic test_signed;
        logic [127:0] av[2];
        logic [127:0] bv[2];
        logic [255:0] ev[2];
        logic [255:0] exp_p;
        int idx, got, cyc;
        av[0] = '1; bv[0] = 128'd3; ev[0] = ~256'd2;
        av[1] = 128'd1 << 127; bv[1] = 128'd1 << 127; ev[1] = 256'd1 << 254;
        idx = 0; got = 0; cyc = 0;
        while (got < 2 && cyc < 40) begin
            @(posedge clock); #1;
            iv = (idx < 2); isg = 1'b1; ordy = 1'b1;
            if (idx < 2) begin a = av[idx]; b = bv[idx]; end
            @(negedge clock);
            if (ov && ordy) begin
                total++;
                if (sb128.size() == 0) begin bad++; $display("FAIL signed_extra got=%h want=none", p); end
                else begin
                    exp_p = sb128.pop_front();
                    if (p !== exp_p) begin bad++; $display("FAIL signed_p got=%h want=%h", p, exp_p); end
                end
                got++;
            end
            if (iv && ir) begin sb128.push_back(ev[idx]); idx++; end
            cyc++;
        end
        iv = 1'b0;
        total++; if (got != 2) begin bad++; $display("FAIL signed_timeout got=%0d want=2", got); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] av[20];
        logic [127:0] bv[20];
        logic         sv[20];
        logic [255:0] exp_p;
        int idx, got, cyc, first, last;
        for (int i = 0; i < 20; i++) begin
            av[i] = {$urandom, $urandom, $urandom, $urandom};
            bv[i] = {$urandom, $urandom, $urandom, $urandom};
            sv[i] = 1'($urandom_range(0, 1));
        end
        av[3] = '0; sv[3] = 1'b1; bv[3] = '1;
        idx = 0; got = 0; cyc = 0; first = -1; last = -1;
        while (got < 20 && cyc < 60) begin
            @(posedge clock); #1;
            iv = (idx < 20); ordy = 1'b1;
            if (idx < 20) begin a = av[idx]; b = bv[idx]; isg = sv[idx]; end
`ifdef KMUL_TAG_EN
            it = 8'(idx);
`endif
            @(negedge clock);
            if (ov && ordy) begin
                total++;
                if (sb128.size() == 0) begin bad++; $display("FAIL b2b_extra got=%h want=none", p); end
                else begin
                    exp_p = sb128.pop_front();
                    if (p !== exp_p) begin bad++; $display("FAIL b2b_p%0d got=%h want=%h", got, p, exp_p); end
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (iv && ir) begin sb128.push_back(ref128(av[idx], bv[idx], sv[idx])); idx++; end
            cyc++;
        end
        iv = 1'b0;
        total++; if (got != 20) begin bad++; $display("FAIL b2b_timeout got=%0d want=20", got); end
        total++; if (last - first != 19) begin bad++; $display("FAIL b2b_rate got=%0d want=19", last - first); end
    endtask

    task automatic test_backpressure;
        logic [127:0] av[8];
        logic [127:0] bv[8];
        logic         sv[8];
        logic [255:0] exp_p, held;
        int idx, got, cyc;
        for (int i = 0; i < 8; i++) begin
            av[i] = {$urandom, $urandom, $urandom, $urandom};
            bv[i] = {$urandom, $urandom, $urandom, $urandom};
            sv[i] = 1'(i % 2);
        end
        idx = 0; got = 0; cyc = 0; held = '0;
        while (got < 8 && cyc < 80) begin
            @(posedge clock); #1;
            iv = (idx < 8); ordy = !(cyc >= 5 && cyc < 11);
            if (idx < 8) begin a = av[idx]; b = bv[idx]; isg = sv[idx]; end
            @(negedge clock);
            if (cyc >= 5 && cyc < 11) begin
                total++;
                if (ir !== 1'b0 || ov !== 1'b1) begin bad++; $display("FAIL bp_stall got=%b%b want=01", ir, ov); end
                if (cyc == 5) held = p;
                else begin
                    total++;
                    if (p !== held) begin bad++; $display("FAIL bp_hold got=%h want=%h", p, held); end
                end
            end
            if (ov && ordy) begin
                total++;
                if (sb128.size() == 0) begin bad++; $display("FAIL bp_extra got=%h want=none", p); end
                else begin
                    exp_p = sb128.pop_front();
                    if (p !== exp_p) begin bad++; $display("FAIL bp_p%0d got=%h want=%h", got, p, exp_p); end
                end
                got++;
            end
            if (iv && ir) begin sb128.push_back(ref128(av[idx], bv[idx], sv[idx])); idx++; end
            cyc++;
        end
        iv = 1'b0; ordy = 1'b1;
        total++; if (got != 8) begin bad++; $display("FAIL bp_timeout got=%0d want=8", got); end
        repeat (3) @(negedge clock);
        total++; if (ov !== 1'b0 || sb128.size() != 0) begin bad++; $display("FAIL bp_dup got=%b/%0d want=0/0", ov, sb128.size()); end
    endtask

    task automatic test_reset_midflight;
        int stale, w;
        bit seen;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            iv = 1'b1; isg = 1'b0; ordy = 1'b1; a = 128'(i + 11); b = 128'(i + 5);
        end
        @(posedge clock); #1;
        iv = 1'b0; reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sb128.delete();
        @(negedge clock);
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", ov); end
        total++; if (p !== '0) begin bad++; $display("FAIL rst_mid_p got=%h want=0", p); end
        stale = 0;
        repeat (10) begin @(negedge clock); if (ov) stale++; end
        total++; if (stale != 0) begin bad++; $display("FAIL rst_mid_stale got=%0d want=0", stale); end
        @(posedge clock); #1;
        iv = 1'b1; isg = 1'b0; a = 128'd7; b = 128'd9;
        @(posedge clock); #1;
        iv = 1'b0;
        seen = 0; w = 0;
        while (!seen && w < 10) begin @(negedge clock); w++; if (ov) seen = 1; end
        total++; if (!seen || p !== 256'd63) begin bad++; $display("FAIL rst_mid_new got=%0d/%h want=1/63", seen, p); end
    endtask

    task automatic test_w16;
        logic [15:0] vals[5];
        logic [31:0] exp_p;
        int idx, got, cyc, m, i, j;
        vals[0] = 16'h0000; vals[1] = 16'h0001; vals[2] = 16'h7FFF; vals[3] = 16'h8000; vals[4] = 16'hFFFF;
        idx = 0; got = 0; cyc = 0;
        while (got < 50 && cyc < 400) begin
            @(posedge clock); #1;
            iv16 = (idx < 50); or16 = ($urandom_range(0, 3) != 0);
            m = idx / 25; i = (idx % 25) / 5; j = idx % 5;
            if (idx < 50) begin a16 = vals[i]; b16 = vals[j]; isg16 = (m == 1); end
`ifdef KMUL_TAG_EN
            it16 = 8'(idx + 100);
`endif
            @(negedge clock);
            if (ov16 && or16) begin
                total++;
                if (sb16.size() == 0) begin bad++; $display("FAIL w16_extra got=%h want=none", p16); end
                else begin
                    exp_p = sb16.pop_front();
                    if (p16 !== exp_p) begin bad++; $display("FAIL w16_p%0d got=%h want=%h", got, p16, exp_p); end
                end
`ifdef KMUL_TAG_EN
                total++;
                if (tq16.size() == 0 || ot16 !== tq16[0]) begin bad++; $display("FAIL w16_tag got=%h want=%h", ot16, (tq16.size() == 0) ? 8'h0 : tq16[0]); end
                if (tq16.size() != 0) void'(tq16.pop_front());
`endif
                got++;
            end
            if (iv16 && ir16) begin
                sb16.push_back(ref16(a16, b16, isg16));
`ifdef KMUL_TAG_EN
                tq16.push_back(it16);
`endif
                idx++;
            end
            cyc++;
        end
        iv16 = 1'b0; or16 = 1'b1;
        total++; if (got != 50) begin bad++; $display("FAIL w16_timeout got=%0d want=50", got); end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_w16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
